// File: rtl/change_pkg.sv
// Shared constants and helpers for the change-event arbiter slice.
package change_pkg;

  localparam int CH_DEFAULT = 4;
  localparam int W_DEFAULT  = 8;
  localparam int MAX_CH     = 16;

  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/change_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
  import change_pkg::*;
#(
  parameter int N  = CH_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic found;

  // Scan offsets from ptr; ptr is always kept below N by the owner.
  always_comb begin
    gnt_onehot = '0;
    found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + k) % N))) begin
          gnt_onehot[j] = 1'b1;
          found         = 1'b1;
        end
      end
    end
  end

  assign any     = |req;
  assign gnt_idx = IW'(onehot_to_idx(MAX_CH'(gnt_onehot)));

endmodule

// File: rtl/change_event_arbiter.sv
// Detects per-channel value changes, queues one event per channel and
// serialises them onto a single valid/ready port in round-robin order.
module change_event_arbiter
  import change_pkg::*;
#(
  parameter int NUM_CH = CH_DEFAULT,
  parameter int WIDTH  = W_DEFAULT,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] sig,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [IDX_W-1:0]        ev_ch,
  output logic [WIDTH-1:0]        ev_data,
  output logic [NUM_CH-1:0]       ovf,
  input  logic [NUM_CH-1:0]       ovf_clr
);

  logic [NUM_CH-1:0][WIDTH-1:0] sig_prev_q;
  logic [NUM_CH-1:0][WIDTH-1:0] snapshot_q, snapshot_d;
  logic [NUM_CH-1:0]            pending_q, pending_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d;
  logic [NUM_CH-1:0]            chg;

  logic                         ev_valid_q, ev_valid_d;
  logic [IDX_W-1:0]             ev_ch_q, ev_ch_d;
  logic [WIDTH-1:0]             ev_data_q, ev_data_d;
  logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;

  logic                         slot_accept;
  logic                         grant_fire;
  logic [NUM_CH-1:0]            gnt_onehot;
  logic [IDX_W-1:0]             gnt_idx;
  logic                         gnt_any;

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chg[i] = ch_enable[i] && (sig[i*WIDTH +: WIDTH] != sig_prev_q[i]);
    end
  end

  // Arbitration sees only already-pending events, never same-cycle changes.
  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req        (pending_q),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign slot_accept = !ev_valid_q || ev_ready;
  assign grant_fire  = slot_accept && gnt_any;

  // A change on the channel being granted keeps it pending with the new value.
  always_comb begin
    pending_d  = pending_q;
    snapshot_d = snapshot_q;
    ovf_d      = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chg[i]) begin
        pending_d[i]  = 1'b1;
        snapshot_d[i] = sig[i*WIDTH +: WIDTH];
      end else if ((grant_fire && gnt_onehot[i]) || !ch_enable[i]) begin
        pending_d[i]  = 1'b0;
      end

      if (chg[i] && pending_q[i] && !(grant_fire && gnt_onehot[i])) begin
        ovf_d[i] = 1'b1;
      end else if (ovf_clr[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    ev_data_d  = ev_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (slot_accept) begin
      ev_valid_d = gnt_any;
      if (gnt_any) begin
        ev_ch_d   = gnt_idx;
        ev_data_d = snapshot_q[gnt_idx];
        rr_ptr_d  = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_prev_q <= '0;
      snapshot_q <= '0;
      pending_q  <= '0;
      ovf_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_data_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      sig_prev_q <= sig;
      snapshot_q <= snapshot_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      ev_data_q  <= ev_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign ev_data  = ev_data_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_change_event_arbiter.sv
// Randomised scoreboard bench for change_event_arbiter with a reference model.
module tb_change_event_arbiter;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic           clk;
  logic           rst;
  logic [NCH*W-1:0] sig;
  logic [NCH-1:0] chEn;
  logic           evValid;
  logic           evReady;
  logic [1:0]     evCh;
  logic [W-1:0]   evData;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] ovfClr;

  int errors = 0;
  int checks = 0;

  // Reference model state, updated at each clock edge from the rules of the block.
  int mPrev [NCH];
  int mSnap [NCH];
  bit mPend [NCH];
  bit mOvf  [NCH];
  bit mValid;
  int mRr;
  int expQ [$];

  change_event_arbiter #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .ch_enable (chEn),
    .ev_valid  (evValid),
    .ev_ready  (evReady),
    .ev_ch     (evCh),
    .ev_data   (evData),
    .ovf       (ovf),
    .ovf_clr   (ovfClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NCH; i++) begin
      mPrev[i] = 0;
      mSnap[i] = 0;
      mPend[i] = 0;
      mOvf[i]  = 0;
    end
    mValid = 0;
    mRr    = 0;
    expQ.delete();
  endfunction

  function automatic void modelStep();
    bit chgNow [NCH];
    int grantCh;
    int v;
    grantCh = -1;
    for (int i = 0; i < NCH; i++) begin
      v = int'(sig[i*W +: W]);
      chgNow[i] = chEn[i] && (v != mPrev[i]);
    end
    if (!mValid || evReady) begin
      for (int k = 0; k < NCH; k++) begin
        if (grantCh < 0 && mPend[(mRr + k) % NCH]) grantCh = (mRr + k) % NCH;
      end
      if (grantCh >= 0) begin
        mValid = 1;
        expQ.push_back(grantCh * 256 + mSnap[grantCh]);
        mRr = (grantCh + 1) % NCH;
      end else begin
        mValid = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      v = int'(sig[i*W +: W]);
      if (chgNow[i] && mPend[i] && grantCh != i) mOvf[i] = 1;
      else if (ovfClr[i]) mOvf[i] = 0;
      if (chgNow[i]) begin
        mPend[i] = 1;
        mSnap[i] = v;
      end else if (grantCh == i || !chEn[i]) begin
        mPend[i] = 0;
      end
      mPrev[i] = v;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) modelStep();
    end
  end

  // Monitor: compares the presented event against the scoreboard head.
  initial begin
    int ovfExp;
    int head;
    forever begin
      @(negedge clk);
      ovfExp = 0;
      for (int i = 0; i < NCH; i++) ovfExp |= int'(mOvf[i]) << i;
      checkOutput("ev_valid", int'(evValid), int'(mValid));
      checkOutput("ovf", int'(ovf), ovfExp);
      if (evValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", int'(evCh) * 256 + int'(evData), -1);
        end else begin
          head = expQ[0];
          checkOutput("ev_ch", int'(evCh), head / 256);
          checkOutput("ev_data", int'(evData), head % 256);
          if (evReady) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setCh(input int c, input int v);
    sig[c*W +: W] = W'(v);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      evReady = ($urandom_range(0, 9) < 7);
      ovfClr  = ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(0, 15)) : '0;
      chEn    = ($urandom_range(0, 9) == 0) ? NCH'($urandom_range(0, 15)) : '1;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 2) == 0) setCh(i, $urandom_range(0, 255));
      end
      tick();
    end
  endtask

  initial begin
    rst     = 1'b1;
    sig     = '0;
    chEn    = '1;
    evReady = 1'b0;
    ovfClr  = '0;
    modelReset();
    #1;
    checkOutput("reset_valid", int'(evValid), 0);
    checkOutput("reset_ch", int'(evCh), 0);
    checkOutput("reset_data", int'(evData), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Two-clock detection latency on channel 2, then drop after accept.
    setCh(2, 'h5A);
    tick(2);
    checkOutput("lat_valid", int'(evValid), 1);
    checkOutput("lat_ch", int'(evCh), 2);
    checkOutput("lat_data", int'(evData), 'h5A);
    evReady = 1'b1;
    tick();
    checkOutput("drop_valid", int'(evValid), 0);

    setCh(0, 'h10); setCh(1, 'h11); setCh(3, 'h13);
    tick(6);

    // Overflow on channel 1 while the consumer stalls.
    evReady = 1'b0;
    setCh(1, 'h01); tick();
    setCh(1, 'h02); tick();
    setCh(1, 'h03); tick();
    checkOutput("ovf1_set", int'(ovf[1]), 1);
    evReady = 1'b1;
    tick(4);
    ovfClr = 4'b0010; tick(); ovfClr = '0;
    checkOutput("ovf1_clr", int'(ovf[1]), 0);
    evReady = 1'b0;
    setCh(1, 'h04); tick();
    setCh(1, 'h05); tick();
    setCh(1, 'h06); ovfClr = 4'b0010; tick(); ovfClr = '0;
    checkOutput("ovf1_set_wins", int'(ovf[1]), 1);
    evReady = 1'b1;
    tick(4);
    ovfClr = '1; tick(); ovfClr = '0;

    // Hold while channel 0 changes under a stalled slot.
    evReady = 1'b0;
    setCh(0, 'h20); tick(2);
    setCh(0, 'h21); tick(3);
    evReady = 1'b1;
    tick(4);

    // Disabled channel ignores toggles; re-enable alone creates nothing.
    chEn = 4'b0111;
    setCh(3, 'hA0); tick();
    setCh(3, 'hA1); tick(2);
    chEn = 4'b1111; tick(3);
    setCh(3, 'hA2); tick(4);

    // Reset in the middle of a transfer with more events pending.
    evReady = 1'b0;
    setCh(0, 'h77); tick(2);
    setCh(1, 'h12); setCh(3, 'h34); tick();
    rst = 1'b1;
    sig = '0;
    modelReset();
    #1;
    checkOutput("midrst_valid", int'(evValid), 0);
    checkOutput("midrst_ch", int'(evCh), 0);
    checkOutput("midrst_data", int'(evData), 0);
    checkOutput("midrst_ovf", int'(ovf), 0);
    tick(2);
    rst = 1'b0;
    evReady = 1'b1;
    tick(5);

    applyStimulus(600);

    evReady = 1'b1;
    chEn    = '1;
    ovfClr  = '0;
    tick(20);
    checkOutput("drain_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
